// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared widths, limits and FSM encoding for the BCD-to-binary converter
package bcd_pkg;

  localparam int NUM_DIGITS    = 3;
  localparam int DIGIT_W       = 4;
  localparam int BIN_W         = 10;
  localparam int SHIFT_COUNT   = 10;
  localparam int MAX_VALUE     = 255;
  localparam int VALUE_W       = 8;
  localparam int BCD_W         = NUM_DIGITS * DIGIT_W;
  localparam int CNT_W         = $clog2(SHIFT_COUNT + 1);
  localparam int DIGIT_MAX     = 9;
  localparam int ADJ_THRESHOLD = 8;
  localparam int ADJ_OFFSET    = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic logic digit_invalid(input logic [DIGIT_W-1:0] digit);
    return int'(digit) > DIGIT_MAX;
  endfunction

endpackage

// File: rtl/bcd_to_binary_if.sv
// rtl/bcd_to_binary_if.sv - request/result bundle between a requester and the converter
interface bcd_if;
  import bcd_pkg::*;

  logic               start;
  logic [DIGIT_W-1:0] hundreds_in;
  logic [DIGIT_W-1:0] tens_in;
  logic [DIGIT_W-1:0] ones_in;
  logic               busy;
  logic               done;
  logic [VALUE_W-1:0] value;
  logic               overflow;
  logic               invalid;

  modport master (
    output start, hundreds_in, tens_in, ones_in,
    input  busy, done, value, overflow, invalid
  );

  modport slave (
    input  start, hundreds_in, tens_in, ones_in,
    output busy, done, value, overflow, invalid
  );

endinterface

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - per-digit correction for one reverse double-dabble step
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [DIGIT_W-1:0] adjusted
);

  assign adjusted = (digit >= DIGIT_W'(ADJ_THRESHOLD)) ? digit - DIGIT_W'(ADJ_OFFSET) : digit;

endmodule

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - three-digit BCD to saturated 8-bit binary, one bit per cycle
module bcd_to_binary
  import bcd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  bcd_if.slave bus
);

  state_t             state_q;
  state_t             state_d;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q;
  logic [VALUE_W-1:0] value_q;
  logic               overflow_q;
  logic               invalid_q;

  logic [BCD_W-1:0]   in_bcd;
  logic               in_bad;
  logic               accept;
  logic               load;
  logic               reject;
  logic               step;
  logic               last_step;
  logic [BCD_W-1:0]   shifted_bcd;
  logic [BIN_W-1:0]   shifted_bin;
  logic [BCD_W-1:0]   adj_bcd;

  assign in_bcd = {bus.hundreds_in, bus.tens_in, bus.ones_in};
  assign in_bad = digit_invalid(bus.hundreds_in) | digit_invalid(bus.tens_in)
                | digit_invalid(bus.ones_in);
  assign accept = (state_q == IDLE) && bus.start;

  // The LSB of the BCD word falls into the top of the binary word each step.
  assign shifted_bcd = {1'b0, bcd_q[BCD_W-1:1]};
  assign shifted_bin = {bcd_q[0], bin_q[BIN_W-1:1]};

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (shifted_bcd[g*DIGIT_W +: DIGIT_W]),
      .adjusted (adj_bcd[g*DIGIT_W +: DIGIT_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !in_bad) state_d = SHIFT;
      SHIFT:   if (last_step)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load      = accept && !in_bad;
    reject    = accept && in_bad;
    step      = (state_q == SHIFT);
    last_step = step && (cnt_q == CNT_W'(1));
    bus.busy  = step;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q      <= '0;
      bin_q      <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      value_q    <= '0;
      overflow_q <= 1'b0;
      invalid_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        bcd_q <= in_bcd;
        bin_q <= '0;
        cnt_q <= CNT_W'(SHIFT_COUNT);
      end
      if (reject) begin
        done_q     <= 1'b1;
        invalid_q  <= 1'b1;
        value_q    <= '0;
        overflow_q <= 1'b0;
      end
      if (step) begin
        bcd_q <= adj_bcd;
        bin_q <= shifted_bin;
        cnt_q <= cnt_q - CNT_W'(1);
        if (last_step) begin
          done_q    <= 1'b1;
          invalid_q <= 1'b0;
          if (shifted_bin > BIN_W'(MAX_VALUE)) begin
            value_q    <= VALUE_W'(MAX_VALUE);
            overflow_q <= 1'b1;
          end else begin
            value_q    <= shifted_bin[VALUE_W-1:0];
            overflow_q <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.done     = done_q;
  assign bus.value    = value_q;
  assign bus.overflow = overflow_q;
  assign bus.invalid  = invalid_q;

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - directed self-checking bench for bcd_to_binary
module tb_bcd_to_binary;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   n;
  logic busy_ok;

  bcd_if bus ();

  bcd_to_binary dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
    bus.hundreds_in = h;
    bus.tens_in     = t;
    bus.ones_in     = o;
  endtask

  // Waits for done after the accepting edge; n ends as the edge count from E0.
  task automatic wait_done();
    n       = 0;
    busy_ok = 1'b1;
    while (!bus.done && n < 30) begin
      if (!bus.busy) busy_ok = 1'b0;
      tick();
      n++;
    end
  endtask

  task automatic conv(input string tag, input logic [3:0] h, input logic [3:0] t,
                      input logic [3:0] o, input logic [7:0] ev, input logic eov);
    set_digits(h, t, o);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done();
    check({tag, "_latency"}, n, 10);
    check({tag, "_busy"}, busy_ok, 1);
    check({tag, "_idle"}, bus.busy, 0);
    check({tag, "_value"}, bus.value, ev);
    check({tag, "_ovf"}, bus.overflow, eov);
    check({tag, "_inv"}, bus.invalid, 0);
    tick();
    check({tag, "_done_clr"}, bus.done, 0);
    check({tag, "_hold"}, bus.value, ev);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    set_digits(4'd0, 4'd0, 4'd0);
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_value", bus.value, 0);
    check("rst_ovf", bus.overflow, 0);
    check("rst_inv", bus.invalid, 0);
    rst_n = 1'b1;
    tick();

    conv("c123", 4'd1, 4'd2, 4'd3, 8'h7B, 1'b0);
    conv("c255", 4'd2, 4'd5, 4'd5, 8'hFF, 1'b0);
    conv("c256", 4'd2, 4'd5, 4'd6, 8'hFF, 1'b1);
    conv("c999", 4'd9, 4'd9, 4'd9, 8'hFF, 1'b1);

    // Invalid digit: done in the accepting cycle, no SHIFT.
    set_digits(4'd0, 4'hA, 4'd3);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("inv_done", bus.done, 1);
    check("inv_flag", bus.invalid, 1);
    check("inv_value", bus.value, 0);
    check("inv_ovf", bus.overflow, 0);
    check("inv_busy", bus.busy, 0);
    tick();
    check("inv_done_clr", bus.done, 0);
    check("inv_busy2", bus.busy, 0);
    check("inv_hold", bus.invalid, 1);
    conv("c007", 4'd0, 4'd0, 4'd7, 8'h07, 1'b0);

    // Restart at E3 and digit churn during SHIFT must not disturb 198.
    set_digits(4'd1, 4'd9, 4'd8);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    set_digits(4'd9, 4'd9, 4'd9);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_digits(4'($urandom), 4'($urandom), 4'($urandom));
      tick();
    end
    n = 9;
    while (!bus.done && n < 30) begin
      tick();
      n++;
    end
    check("rest_latency", n, 10);
    check("rest_value", bus.value, 8'hC6);
    check("rest_ovf", bus.overflow, 0);
    tick();

    // Reset between E4 and E5 aborts the conversion.
    set_digits(4'd5, 4'd5, 4'd5);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_value", bus.value, 0);
    bus.start = 1'b1;
    tick();
    tick();
    check("abort_rst_start", bus.busy, 0);
    bus.start = 1'b0;
    rst_n     = 1'b1;
    busy_ok   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.done || bus.busy) busy_ok = 1'b0;
      tick();
    end
    check("abort_quiet", busy_ok, 1);
    conv("c042", 4'd0, 4'd4, 4'd2, 8'h2A, 1'b0);

    // Back-to-back with start held high.
    set_digits(4'd0, 4'd0, 4'd0);
    bus.start = 1'b1;
    tick();
    wait_done();
    check("b2b_lat0", n, 10);
    check("b2b_val0", bus.value, 0);
    set_digits(4'd1, 4'd0, 4'd0);
    tick();
    check("b2b_done_clr", bus.done, 0);
    wait_done();
    check("b2b_gap", n + 1, 11);
    check("b2b_val1", bus.value, 8'd100);
    check("b2b_ovf1", bus.overflow, 0);
    bus.start = 1'b0;
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_to_binary.md
BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed by package constants.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  request a conversion of the three digit inputs; sampled only in IDLE.
REQ-006 hundreds_in  input  4  BCD hundreds digit.
REQ-007 tens_in  input  4  BCD tens digit.
REQ-008 ones_in  input  4  BCD ones digit.
REQ-009 busy  output  1  conversion in progress.
REQ-010 done  output  1  one-cycle pulse; result outputs are valid from this cycle.
REQ-011 value  output  8  binary result, saturated to 255.
REQ-012 overflow  output  1  decimal input exceeded 255.
REQ-013 invalid  output  1  an input digit exceeded 9.

Function
REQ-014 The FSM SHALL have two states, IDLE and SHIFT.
REQ-015 In IDLE with start=1 at edge E0, the block SHALL:
- latch {hundreds_in, tens_in, ones_in} into a 12-bit BCD register;
- clear a 10-bit binary register;
- load the shift counter with 10;
- enter SHIFT with busy=1.
REQ-016 At each of edges E1..E10, SHIFT SHALL perform one reverse double-dabble step:
- shift {bcd, bin} right by one, so bcd[0] enters bin[9];
- then subtract 3 from every 4-bit BCD digit that is now >= 8;
- decrement the counter.
REQ-017 At edge E10, the block SHALL:
- return to IDLE with busy=0;
- pulse done=1 for exactly one cycle (cleared at E11);
- update value, overflow and invalid.
REQ-018 Result rules:
- bin <= 255: value=bin[7:0], overflow=0.
- bin > 255: value=8'hFF, overflow=1.
- A valid conversion SHALL clear invalid.
REQ-019 If any latched digit > 9 at E0, the block SHALL NOT enter SHIFT; at E0 it SHALL set invalid=1, done=1, value=0, overflow=0, with busy remaining 0.
REQ-020 start while busy=1 SHALL be ignored, with no effect on the in-flight conversion.
REQ-021 Input digits SHALL be don't-care after E0; changes during SHIFT SHALL NOT affect the result.
REQ-022 value, overflow and invalid SHALL hold until the next done pulse.
REQ-023 Back-to-back operation: start=1 in the done cycle SHALL be accepted at E11, giving a sustained throughput of one conversion per 11 cycles.
REQ-024 Latency SHALL be exactly 10 edges from start acceptance to done for valid input, and 0 edges (done at E0) for invalid input.

Reset
REQ-025 rst_n=0 SHALL asynchronously force:
- state=IDLE;
- busy=0, done=0, value=0, overflow=0, invalid=0;
- counter and internal registers to 0.
REQ-026 Reset asserted mid-conversion SHALL abort the conversion with no done pulse; the first start after release SHALL behave as from power-up.
REQ-027 start SHALL be ignored while rst_n=0.

Structure
REQ-028 A shared package bcd_pkg SHALL hold:
- the FSM state enum (IDLE, SHIFT);
- NUM_DIGITS=3, DIGIT_W=4, BIN_W=10, SHIFT_COUNT=10, MAX_VALUE=255.
REQ-029 One combinational sub-module, bcd_digit_adjust, SHALL implement the per-digit ">= 8 then subtract 3" correction, instantiated NUM_DIGITS times.
REQ-030 The counter SHALL be sized from SHIFT_COUNT via the package; no magic numbers in the RTL.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Digits 1,2,3 with start pulse -> busy for 10 cycles; done at E10 with value=8'h7B, overflow=0, invalid=0.
- Digits 2,5,5 -> value=8'hFF, overflow=0; then 2,5,6 -> value=8'hFF, overflow=1; then 9,9,9 -> value=8'hFF, overflow=1.
- Digits 0,A,3 -> done at E0 with invalid=1, value=0, busy never asserted; next valid conversion 0,0,7 -> value=7, invalid=0.
- start re-pulsed at E3 with different digits -> ignored; result matches first digits; input digits toggled during SHIFT -> result unchanged.
- rst_n dropped at E5 -> outputs 0 immediately, no done; after release, 0,4,2 -> value=8'h2A at E10.
- Back-to-back: start held high continuously with 0,0,0 then 1,0,0 -> done pulses 11 cycles apart, values 0 then 100.
